// File: rtl/demux_1_8_4_bits_reg.sv
// ---------------------------------------------------------------------------
// demux_1_8_4_bits_reg
//   Write side of the 8-entry register bank. One data input is steered into
//   one of eight registers, either by the 3-bit select {s0,s1,s2} (manual
//   mode) or by an internal auto-fill pointer that advances after each
//   accepted write. Per-entry valid flags plus a full flag tell the datapath
//   when a bank load is complete. An auto write into a full bank is rejected
//   and flagged with a one-cycle ovf pulse.
//
// Ports
//   clock         rising-edge clock
//   resetn        asynchronous active-low reset
//   s0, s1, s2    manual select, index = {s0,s1,s2} (s0 is the MSB)
//   in            write data
//   wr            write strobe
//   auto          1 = write at ptr, 0 = write at {s0,s1,s2}
//   clr           synchronous bank clear, has priority over wr
//   out0..out7    registered bank contents
//   valid         valid[i] = entry i written since reset/clear
//   ptr           auto-fill pointer
//   full          all eight entries valid
//   ovf           rejected auto write on the previous edge
// ---------------------------------------------------------------------------
module demux_1_8_4_bits_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic [WIDTH-1:0] in,
    input  logic             wr,
    input  logic             auto,
    input  logic             clr,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [7:0]       valid,
    output logic [2:0]       ptr,
    output logic             full,
    output logic             ovf
);

    logic [WIDTH-1:0] bank_q [8];
    logic [WIDTH-1:0] bank_d [8];
    logic [7:0]       valid_d;
    logic [2:0]       ptr_d;
    logic             full_d;
    logic             ovf_d;
    logic [2:0]       sel;

    assign sel = {s0, s1, s2};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bank_d[i] = bank_q[i];
        end
        valid_d = valid;
        ptr_d   = ptr;
        ovf_d   = 1'b0;

        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                bank_d[i] = '0;
            end
            valid_d = '0;
            ptr_d   = '0;
        end else if (wr) begin
            if (!auto) begin
                bank_d[sel]  = in;
                valid_d[sel] = 1'b1;
            end else if (full) begin
                ovf_d = 1'b1;
            end else begin
                // ptr walks linearly and does not skip manually written
                // entries, so it may overwrite them while the bank is not full
                bank_d[ptr]  = in;
                valid_d[ptr] = 1'b1;
                ptr_d        = ptr + 3'd1;
            end
        end

        // derived from the next valid vector so full rises together with
        // the last valid bit rather than one cycle later
        full_d = &valid_d;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= '0;
            end
            valid <= '0;
            ptr   <= '0;
            full  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= bank_d[i];
            end
            valid <= valid_d;
            ptr   <= ptr_d;
            full  <= full_d;
            ovf   <= ovf_d;
        end
    end

    assign out0 = bank_q[0];
    assign out1 = bank_q[1];
    assign out2 = bank_q[2];
    assign out3 = bank_q[3];
    assign out4 = bank_q[4];
    assign out5 = bank_q[5];
    assign out6 = bank_q[6];
    assign out7 = bank_q[7];

endmodule

// File: tb/tb_demux_1_8_4_bits_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1_8_4_bits_reg
//   Self-checking bench for demux_1_8_4_bits_reg. Directed scenarios followed
//   by randomized traffic, every step compared against a behavioural model
//   of the register bank.
// ---------------------------------------------------------------------------
module tb_demux_1_8_4_bits_reg;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    logic [3:0] in = 4'h0;
    logic       wr = 1'b0, auto = 1'b0, clr = 1'b0;
    logic [3:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0] valid;
    logic [2:0] ptr;
    logic       full, ovf;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [3:0] m_reg   [8];
    bit         m_valid [8];
    int         m_ptr;
    bit         m_ovf;

    demux_1_8_4_bits_reg #(.WIDTH(4)) dut (
        .clock (clock),
        .resetn(resetn),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .in    (in),
        .wr    (wr),
        .auto  (auto),
        .clr   (clr),
        .out0  (out0),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3),
        .out4  (out4),
        .out5  (out5),
        .out6  (out6),
        .out7  (out7),
        .valid (valid),
        .ptr   (ptr),
        .full  (full),
        .ovf   (ovf)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] dut_out(input int i);
        case (i)
            0: return out0;
            1: return out1;
            2: return out2;
            3: return out3;
            4: return out4;
            5: return out5;
            6: return out6;
            default: return out7;
        endcase
    endfunction

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_valid[i]) n++;
        return n == 8;
    endfunction

    function automatic logic [7:0] model_valid_vec();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) if (m_valid[i]) v = v | (8'd1 << i);
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_reg[i]   = 4'h0;
            m_valid[i] = 1'b0;
        end
        m_ptr = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic a, input logic [2:0] sel,
                              input logic [3:0] d, input logic c);
        bit was_full = model_full();
        m_ovf = 1'b0;
        if (c) begin
            model_clear();
        end else if (w && !a) begin
            m_reg[sel]   = d;
            m_valid[sel] = 1'b1;
        end else if (w && a) begin
            if (was_full) begin
                m_ovf = 1'b1;
            end else begin
                m_reg[m_ptr]   = d;
                m_valid[m_ptr] = 1'b1;
                m_ptr          = (m_ptr + 1) % 8;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_out%0d", tag, i), {4'h0, dut_out(i)}, {4'h0, m_reg[i]});
        end
        chk({tag, "_valid"}, valid, model_valid_vec());
        chk({tag, "_ptr"}, {5'd0, ptr}, 8'(m_ptr));
        chk({tag, "_full"}, {7'd0, full}, {7'd0, model_full()});
        chk({tag, "_ovf"}, {7'd0, ovf}, {7'd0, m_ovf});
    endtask

    task automatic step(input string tag, input logic w, input logic a,
                        input logic [2:0] sel, input logic [3:0] d, input logic c);
        @(negedge clock);
        wr = w; auto = a; {s0, s1, s2} = sel; in = d; clr = c;
        @(posedge clock);
        model_edge(w, a, sel, d, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_clear();

        // reset state while resetn is held low
        #2;
        check_all("rst_init");
        @(negedge clock);
        resetn = 1'b1;

        // manual write to index 5
        step("man5", 1'b1, 1'b0, 3'b101, 4'hA, 1'b0);
        chk("man5_lit_out5", {4'h0, out5}, 8'h0A);
        chk("man5_lit_valid", valid, 8'h20);
        step("clr1", 1'b0, 1'b0, 3'b000, 4'h0, 1'b1);

        // auto fill 1..8, ptr wraps, full after the 8th write
        for (int k = 0; k < 8; k++) begin
            step($sformatf("fill%0d", k), 1'b1, 1'b1, 3'($urandom_range(0, 7)), 4'(k + 1), 1'b0);
        end
        chk("fill_lit_out7", {4'h0, out7}, 8'h08);
        chk("fill_lit_full", {7'd0, full}, 8'h01);
        chk("fill_lit_ptr", {5'd0, ptr}, 8'h00);

        // overflow pulse, then manual overwrite while full
        step("ovf", 1'b1, 1'b1, 3'b011, 4'hF, 1'b0);
        chk("ovf_lit", {7'd0, ovf}, 8'h01);
        step("ovf_end", 1'b0, 1'b1, 3'b011, 4'hF, 1'b0);
        step("man0_full", 1'b1, 1'b0, 3'b000, 4'hC, 1'b0);
        chk("man0_lit_out0", {4'h0, out0}, 8'h0C);

        // clear beats a simultaneous auto write
        step("clr_pre", 1'b0, 1'b0, 3'b000, 4'h0, 1'b1);
        step("auto_a", 1'b1, 1'b1, 3'b000, 4'h3, 1'b0);
        step("auto_b", 1'b1, 1'b1, 3'b000, 4'h4, 1'b0);
        step("clr_wr", 1'b1, 1'b1, 3'b110, 4'h9, 1'b1);
        chk("clr_wr_lit_valid", valid, 8'h00);

        // hold with wr low and other inputs toggling
        step("hold_seed", 1'b1, 1'b0, 3'b010, 4'h6, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step($sformatf("hold%0d", k), 1'b0, 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);
        end

        // asynchronous reset mid-fill after three auto writes
        step("mid_clr", 1'b0, 1'b0, 3'b000, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("mid%0d", k), 1'b1, 1'b1, 3'b000, 4'(k + 5), 1'b0);
        end
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        @(negedge clock);
        wr = 1'b0;
        resetn = 1'b1;
        step("post_rst", 1'b1, 1'b1, 3'b000, 4'h7, 1'b0);

        // randomized mixed-mode traffic
        for (int k = 0; k < 400; k++) begin
            step($sformatf("rnd%0d", k),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 23) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
